// File: rtl/mem_req_if.sv
// mem_req_if: request, response and memory-command signals between the arbiter and its neighbours
interface mem_req_if #(parameter int WIDTH = 2, parameter int PSIZE = 2);
   logic             wr_valid, wr_ready, rd_valid, rd_ready;
   logic [PSIZE-1:0] wr_addr, rd_addr;
   logic [WIDTH-1:0] wr_data;
   logic             rsp_valid, rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             mem_wr, mem_rd;
   logic [PSIZE-1:0] mem_wr_addr, mem_rd_addr;
   logic [WIDTH-1:0] mem_wr_data, mem_rd_data;
   modport slave (
      input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready, mem_rd_data,
      output wr_ready, rd_ready, rsp_valid, rsp_data, mem_wr, mem_rd, mem_wr_addr, mem_rd_addr, mem_wr_data
   );
   modport master (
      output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready, mem_rd_data,
      input  wr_ready, rd_ready, rsp_valid, rsp_data, mem_wr, mem_rd, mem_wr_addr, mem_rd_addr, mem_wr_data
   );
endinterface

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin write/read arbiter in front of a 2-port register memory;
// the read response is held in the memory's own output register.
module mem_req_arbiter #(parameter int WIDTH = 2, parameter int PSIZE = 2) (
   input logic clk,
   input logic rst_n,
   mem_req_if.slave bus
);
   logic             prio, held, rd_ok, wr_gnt, rd_gnt;
   logic [PSIZE-1:0] wa, ra;
   logic [WIDTH-1:0] wd, rdata;
   always_comb begin
      rd_ok  = bus.rd_valid && (!held || bus.rsp_ready);
      wr_gnt = rst_n && bus.wr_valid && (!rd_ok || !prio);
      rd_gnt = rst_n && rd_ok && (!bus.wr_valid || prio);
      wa     = bus.wr_addr;
      ra     = bus.rd_addr;
      wd     = bus.wr_data;
      rdata  = bus.mem_rd_data;
   end
   assign bus.wr_ready    = wr_gnt;
   assign bus.mem_wr      = wr_gnt;
   assign bus.rd_ready    = rd_gnt;
   assign bus.mem_rd      = rd_gnt;
   assign bus.mem_wr_addr = wa;
   assign bus.mem_rd_addr = ra;
   assign bus.mem_wr_data = wd;
   assign bus.rsp_data    = rdata;
   assign bus.rsp_valid   = held;
   // a contended cycle always hands priority to whichever side just lost
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         prio <= 1'b0;
         held <= 1'b0;
      end else begin
         if (bus.wr_valid && rd_ok) prio <= !prio;
         held <= rd_gnt || (held && !bus.rsp_ready);
      end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed and random stimulus with a scoreboard on the read response channel
module tb_mem_req_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   mem_req_if #(.WIDTH(2), .PSIZE(2)) bus();
   mem_req_arbiter #(.WIDTH(2), .PSIZE(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   logic [1:0] mem [4];
   logic [1:0] mem_out;
   assign bus.mem_rd_data = mem_out;
   always @(posedge clk)
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) mem[i] <= 2'd0;
         mem_out <= 2'd0;
      end else begin
         if (bus.mem_wr) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
         if (bus.mem_rd) mem_out <= mem[bus.mem_rd_addr];
      end
   task automatic check(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", n, act, exp, $time);
      end
   endtask
   logic [1:0] model_mem [4];
   logic [1:0] exp_q [$];
   logic       hold_v;
   logic [1:0] hold_d;
   initial hold_v = 1'b0;
   always @(negedge clk)
      if (!rst_n) begin
         exp_q.delete();
         for (int i = 0; i < 4; i++) model_mem[i] = 2'd0;
         hold_v = 1'b0;
      end else begin
         check("excl", int'(bus.mem_wr && bus.mem_rd), 0);
         if (hold_v && bus.rsp_valid) check("rsp_hold", int'(bus.rsp_data), int'(hold_d));
         hold_v = bus.rsp_valid && !bus.rsp_ready;
         hold_d = bus.rsp_data;
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
            else check("rsp_data", int'(bus.rsp_data), int'(exp_q.pop_front()));
         end
         if (bus.wr_valid && bus.wr_ready) model_mem[bus.wr_addr] = bus.wr_data;
         if (bus.rd_valid && bus.rd_ready) exp_q.push_back(model_mem[bus.rd_addr]);
      end
   task automatic drive(input int wv, input int wa, input int wd, input int rv, input int ra, input int rr);
      bus.wr_valid  = wv[0];
      bus.wr_addr   = wa[1:0];
      bus.wr_data   = wd[1:0];
      bus.rd_valid  = rv[0];
      bus.rd_addr   = ra[1:0];
      bus.rsp_ready = rr[0];
   endtask
   task automatic nxt;
      @(posedge clk);
      #1;
   endtask
   logic [1:0] val [4];
   initial begin
      val = '{2'd1, 2'd2, 2'd3, 2'd0};
      drive(1, 0, 0, 1, 0, 1);
      @(negedge clk);
      check("rst_wr_ready", int'(bus.wr_ready), 0);
      check("rst_rd_ready", int'(bus.rd_ready), 0);
      check("rst_mem_wr", int'(bus.mem_wr), 0);
      check("rst_mem_rd", int'(bus.mem_rd), 0);
      check("rst_rsp_valid", int'(bus.rsp_valid), 0);
      nxt();
      rst_n = 1'b1;
      drive(1, 2, 3, 0, 0, 1);
      @(negedge clk);
      check("t1_wr_ready", int'(bus.wr_ready), 1);
      check("t1_mem_wr", int'(bus.mem_wr), 1);
      check("t1_wr_addr", int'(bus.mem_wr_addr), 2);
      check("t1_wr_data", int'(bus.mem_wr_data), 3);
      nxt();
      drive(0, 0, 0, 1, 2, 1);
      @(negedge clk);
      check("t1_rd_ready", int'(bus.rd_ready), 1);
      check("t1_rd_addr", int'(bus.mem_rd_addr), 2);
      nxt();
      drive(0, 0, 0, 0, 0, 1);
      @(negedge clk);
      check("t1_rsp_valid", int'(bus.rsp_valid), 1);
      check("t1_rsp_data", int'(bus.rsp_data), 3);
      nxt();
      for (int i = 0; i < 6; i++) begin
         drive(1, i % 4, i % 4, 1, 3, 1);
         @(negedge clk);
         check("t2_wr_grant", int'(bus.wr_ready), int'(i % 2 == 0));
         check("t2_rd_grant", int'(bus.rd_ready), int'(i % 2 == 1));
         nxt();
      end
      drive(0, 0, 0, 0, 0, 1);
      nxt();
      drive(1, 1, 2, 0, 0, 1);
      nxt();
      drive(0, 0, 0, 1, 1, 1);
      @(negedge clk);
      check("t3_rd_ready", int'(bus.rd_ready), 1);
      nxt();
      for (int i = 0; i < 4; i++) begin
         drive(1, 3, 1, 1, 0, 0);
         @(negedge clk);
         check("t3_rd_blocked", int'(bus.rd_ready), 0);
         check("t3_wr_ready", int'(bus.wr_ready), 1);
         check("t3_rsp_valid", int'(bus.rsp_valid), 1);
         check("t3_rsp_data", int'(bus.rsp_data), 2);
         nxt();
      end
      drive(0, 0, 0, 1, 0, 1);
      @(negedge clk);
      check("t3_rd_resume", int'(bus.rd_ready), 1);
      nxt();
      drive(0, 0, 0, 0, 0, 1);
      nxt();
      for (int k = 0; k < 4; k++) begin
         drive(1, k, int'(val[k]), 0, 0, 1);
         nxt();
      end
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 0, 1, k, 1);
         @(negedge clk);
         check("t4_rd_ready", int'(bus.rd_ready), 1);
         if (k > 0) begin
            check("t4_rsp_valid", int'(bus.rsp_valid), 1);
            check("t4_rsp_data", int'(bus.rsp_data), int'(val[k-1]));
         end
         nxt();
      end
      drive(0, 0, 0, 0, 0, 1);
      @(negedge clk);
      check("t4_last_valid", int'(bus.rsp_valid), 1);
      check("t4_last_data", int'(bus.rsp_data), int'(val[3]));
      nxt();
      @(negedge clk);
      check("t4_drained", int'(bus.rsp_valid), 0);
      nxt();
      drive(1, 0, 2, 1, 0, 1);
      @(negedge clk);
      check("t5_pre_wr", int'(bus.wr_ready), 1);
      check("t5_pre_rd", int'(bus.rd_ready), 0);
      nxt();
      drive(0, 0, 0, 1, 0, 0);
      nxt();
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("t5_held", int'(bus.rsp_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_rst_rsp_valid", int'(bus.rsp_valid), 0);
      nxt();
      nxt();
      drive(1, 1, 1, 1, 1, 1);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      check("t5_prio_wr", int'(bus.wr_ready), 1);
      check("t5_prio_rd", int'(bus.rd_ready), 0);
      nxt();
      for (int i = 0; i < 10000; i++) begin
         drive(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3) != 0));
         nxt();
      end
      drive(0, 0, 0, 0, 0, 1);
      repeat (3) nxt();
      check("drain_queue", exp_q.size(), 0);
      check("drain_valid", int'(bus.rsp_valid), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
